// File: rtl/led_show_pkg.sv
// led_show_pkg: mode codes, colours, fade constants and the VU bar-length helper.
package led_show_pkg;
  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_VU    = 2'd1;
  localparam logic [1:0] MODE_CHASE = 2'd2;
  localparam logic [1:0] MODE_FADE  = 2'd3;
  localparam logic [23:0] C_GREEN  = 24'h00FC00;
  localparam logic [23:0] C_YELLOW = 24'hFCFC00;
  localparam logic [23:0] C_RED    = 24'hFC0000;
  localparam logic [23:0] C_WHITE  = 24'hFFFFFF;
  localparam logic [23:0] C_DIM    = 24'h202020;
  localparam logic [7:0] FADE_STEP = 8'd4;
  localparam logic [7:0] FADE_MAX  = 8'd252;
  // Number of lit LEDs for a level: (level*n)>>8 on a 24-bit product.
  function automatic logic [15:0] lit_of(input logic [7:0] l, input logic [15:0] n);
    logic [23:0] p;
    p = {16'd0, l} * {8'd0, n};
    return 16'(p >> 8);
  endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-FF synchroniser plus stable-time filter; one-cycle pulse per debounced press.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s0, s1, stable;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0     <= 1'b0;
      s1     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      s0    <= button;
      s1    <= s0;
      press <= 1'b0;
      if (s1 == stable) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt    <= '0;
        stable <= s1;
        press  <= s1;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/led_show_ctrl.sv
// led_show_ctrl: per-pixel RGB source for the LED tape driver, frame-synchronous mode/level updates.
module led_show_ctrl
  import led_show_pkg::*;
#(
  parameter int NUM_LEDS        = 160,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CHASE_DIV       = 2,
  parameter int PEAK_DECAY      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        button,
  input  logic [7:0]  level,
  input  logic        tape_req,
  input  logic [15:0] tape_num,
  input  logic        tape_sync,
  output logic [23:0] rgb,
  output logic [1:0]  mode
);
  localparam logic [15:0] N16  = 16'(NUM_LEDS);
  localparam logic [15:0] HALF = 16'(NUM_LEDS / 2);
  localparam logic [15:0] TQ   = 16'(3 * NUM_LEDS / 4);
  logic press, prev_sync, fade_dir, fb, chase_step;
  logic [1:0] pend, pend_nxt;
  logic [7:0] lvl, fade, fade_nxt;
  logic [15:0] peak, pos, prv, frame, frame_nxt, dec_cnt, lit, lit_new;
  logic [23:0] vu_pix, ch_pix, fd_pix, pix;
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk(clk), .reset_n(reset_n), .button(button), .press(press)
  );
  // Frame boundary: first sync request following a non-sync request.
  assign fb         = tape_req & tape_sync & ~prev_sync;
  assign pend_nxt   = press ? pend + 2'd1 : pend;
  assign frame_nxt  = frame + 16'd1;
  assign chase_step = (frame_nxt % 16'(CHASE_DIV)) == 16'd0;
  assign fade_nxt   = fade_dir ? fade - FADE_STEP : fade + FADE_STEP;
  assign lit        = lit_of(lvl, N16);
  assign lit_new    = lit_of(level, N16);
  assign prv        = (pos == 16'd0) ? N16 - 16'd1 : pos - 16'd1;
  always_comb begin
    vu_pix = (peak != 16'd0 && tape_num == peak - 16'd1) ? C_WHITE :
             (tape_num >= lit) ? 24'd0 :
             (tape_num < HALF) ? C_GREEN :
             (tape_num < TQ)   ? C_YELLOW : C_RED;
    ch_pix = (tape_num == pos) ? C_WHITE : (tape_num == prv) ? C_DIM : 24'd0;
    fd_pix = {fade, 8'd0, FADE_MAX - fade};
    pix    = (tape_sync || tape_num >= N16) ? 24'd0 :
             (mode == MODE_VU)    ? vu_pix :
             (mode == MODE_CHASE) ? ch_pix :
             (mode == MODE_FADE)  ? fd_pix : 24'd0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb       <= '0;
      mode      <= MODE_OFF;
      pend      <= MODE_OFF;
      prev_sync <= 1'b0;
      lvl       <= '0;
      peak      <= '0;
      pos       <= '0;
      frame     <= '0;
      dec_cnt   <= '0;
      fade      <= '0;
      fade_dir  <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (tape_req) begin
        rgb       <= pix;
        prev_sync <= tape_sync;
      end
      if (fb) begin
        mode  <= pend_nxt;
        lvl   <= level;
        frame <= frame_nxt;
        if (chase_step) pos <= (pos == N16 - 16'd1) ? 16'd0 : pos + 16'd1;
        if (lit_new > peak) begin
          peak    <= lit_new;
          dec_cnt <= '0;
        end else if (dec_cnt == 16'(PEAK_DECAY - 1)) begin
          dec_cnt <= '0;
          peak    <= (peak == 16'd0) ? peak : peak - 16'd1;
        end else dec_cnt <= dec_cnt + 16'd1;
        fade <= fade_nxt;
        if (fade_nxt == FADE_MAX) fade_dir <= 1'b1;
        else if (fade_nxt == 8'd0) fade_dir <= 1'b0;
      end
    end
  end
endmodule
